// File: rtl/game_io_mmio.sv
// Memory-mapped I/O window for the game core: debounced buttons,
// sticky press events, frame tick counter and game-state registers.
module game_io_mmio #(
  parameter logic [11:0] IO_BASE = 12'hF00,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] io_address,
  input  logic [31:0] io_wdata,
  input  logic        io_wren,
  input  logic        io_rden,
  input  logic [3:0]  btn_in,
  input  logic        frame_tick,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic [7:0]  level_out,
  output logic [3:0]  screen_out,
  output logic        game_over_out
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [3:0] OFF_STATE = 4'd0;
  localparam logic [3:0] OFF_EVENT = 4'd1;
  localparam logic [3:0] OFF_LEVEL = 4'd2;
  localparam logic [3:0] OFF_SCRN  = 4'd3;
  localparam logic [3:0] OFF_OVER  = 4'd4;
  localparam logic [3:0] OFF_TICK  = 4'd5;

  logic [3:0]       off;
  logic             wr_en;
  logic             evt_clr;
  logic             hit_state;
  logic             hit_event;
  logic             hit_level;
  logic             hit_scrn;
  logic             hit_over;
  logic             hit_tick;

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       deb;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       accept;
  logic [3:0]       rise;
  logic [3:0]       evt;

  logic [7:0]       level_q;
  logic [3:0]       screen_q;
  logic             over_q;
  logic [31:0]      tick_q;

  logic             unused_wdata;

  assign unused_wdata = ^io_wdata[31:8];

  assign off    = io_address[3:0];
  assign io_sel = io_address[11:4] == IO_BASE[11:4];
  assign wr_en  = io_wren & io_sel;

  assign hit_state = off == OFF_STATE;
  assign hit_event = off == OFF_EVENT;
  assign hit_level = off == OFF_LEVEL;
  assign hit_scrn  = off == OFF_SCRN;
  assign hit_over  = off == OFF_OVER;
  assign hit_tick  = off == OFF_TICK;

  assign evt_clr = io_rden & io_sel & hit_event;

  // A bit is accepted once it has differed from deb for the full window.
  always_comb begin
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      accept[i] = (s2[i] != deb[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign rise = accept & s2;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // A press landing on the clearing read survives it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      evt <= '0;
    end else begin
      evt <= (evt_clr ? 4'b0 : evt) | rise;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      level_q  <= '0;
      screen_q <= '0;
      over_q   <= 1'b0;
    end else if (wr_en) begin
      if (hit_level) begin
        level_q <= io_wdata[7:0];
      end
      if (hit_scrn) begin
        screen_q <= io_wdata[3:0];
      end
      if (hit_over) begin
        over_q <= io_wdata[0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_q <= '0;
    end else if (wr_en && hit_tick) begin
      tick_q <= '0;
    end else if (frame_tick) begin
      tick_q <= tick_q + 32'd1;
    end
  end

  always_comb begin
    io_rdata = '0;
    if (io_sel) begin
      unique case (1'b1)
        hit_state: io_rdata = {28'b0, deb};
        hit_event: io_rdata = {28'b0, evt};
        hit_level: io_rdata = {24'b0, level_q};
        hit_scrn:  io_rdata = {28'b0, screen_q};
        hit_over:  io_rdata = {31'b0, over_q};
        hit_tick:  io_rdata = tick_q;
        default:   io_rdata = '0;
      endcase
    end
  end

  assign level_out     = level_q;
  assign screen_out    = screen_q;
  assign game_over_out = over_q;

endmodule

// File: tb/tb_game_io_mmio.sv
// Bench for game_io_mmio: scoreboard queue of expected values,
// one task per feature, all driven from a single initial block.
module tb_game_io_mmio;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] io_address;
  logic [31:0] io_wdata;
  logic        io_wren;
  logic        io_rden;
  logic [3:0]  btn_in;
  logic        frame_tick;
  logic        io_sel;
  logic [31:0] io_rdata;
  logic [7:0]  level_out;
  logic [3:0]  screen_out;
  logic        game_over_out;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] exp;

  always #5 clock = ~clock;

  game_io_mmio #(
    .IO_BASE(12'hF00),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_address(io_address),
    .io_wdata(io_wdata),
    .io_wren(io_wren),
    .io_rden(io_rden),
    .btn_in(btn_in),
    .frame_tick(frame_tick),
    .io_sel(io_sel),
    .io_rdata(io_rdata),
    .level_out(level_out),
    .screen_out(screen_out),
    .game_over_out(game_over_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] d);
    io_address = a;
    #1;
    d = io_rdata;
  endtask

  task automatic read_word(input logic [11:0] a, output logic [31:0] d);
    io_address = a;
    io_rden = 1'b1;
    #1;
    d = io_rdata;
    tick();
    io_rden = 1'b0;
  endtask

  task automatic write_word(input logic [11:0] a, input logic [31:0] w);
    io_address = a;
    io_wdata = w;
    io_wren = 1'b1;
    tick();
    io_wren = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    write_word(12'hF02, 32'h55);
    exp_q.push_back(32'h55);
    got = {24'b0, level_out};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL level_pre_reset got %h want %h", got, exp);
    else passed++;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    got = {24'b0, level_out};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL level_reset got %h want %h", got, exp);
    else passed++;
    got = {28'b0, screen_out};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL screen_reset got %h want %h", got, exp);
    else passed++;
    got = {31'b0, game_over_out};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL over_reset got %h want %h", got, exp);
    else passed++;
    exp_q.push_back(32'h0);
    peek(12'hF05, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL tick_reset got %h want %h", got, exp);
    else passed++;
  endtask

  task automatic test_regs();
    write_word(12'hF02, 32'h1A3);
    write_word(12'hF03, 32'h7);
    write_word(12'hF04, 32'h1);
    write_word(12'hF06, 32'hFF);
    exp_q.push_back(32'hA3);
    exp_q.push_back(32'h7);
    exp_q.push_back(32'h1);
    got = {24'b0, level_out};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL level_out got %h want %h", got, exp);
    else passed++;
    got = {28'b0, screen_out};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL screen_out got %h want %h", got, exp);
    else passed++;
    got = {31'b0, game_over_out};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL over_out got %h want %h", got, exp);
    else passed++;
    begin
      logic [11:0] addrs [5];
      logic [31:0] want [5];
      addrs = '{12'hF02, 12'hF03, 12'hF04, 12'hF06, 12'hF12};
      want  = '{32'hA3, 32'h7, 32'h1, 32'h0, 32'h0};
      for (int i = 0; i < 5; i++) begin
        exp_q.push_back(want[i]);
        read_word(addrs[i], got);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp)
          $display("FAIL readback[%0d] addr %h got %h want %h",
                   i, addrs[i], got, exp);
        else passed++;
      end
    end
    exp_q.push_back(32'h0);
    peek(12'hF10, got);
    checks++;
    if (io_sel !== 1'b0) $display("FAIL io_sel_f10 got %b want 0", io_sel);
    else passed++;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL rdata_f10 got %h want %h", got, exp);
    else passed++;
  endtask

  task automatic test_debounce();
    btn_in = 4'b0100;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_q.push_back(e < 6 ? 32'h0 : 32'h4);
      peek(12'hF00, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp)
        $display("FAIL deb_edge%0d got %h want %h", e, got, exp);
      else passed++;
    end
    btn_in = 4'b0110;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) btn_in = 4'b0100;
      tick();
      exp_q.push_back(32'h4);
      peek(12'hF00, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp)
        $display("FAIL bounce_edge%0d got %h want %h", e, got, exp);
      else passed++;
    end
  endtask

  task automatic test_event();
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h0);
    read_word(12'hF01, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL evt_first got %h want %h", got, exp);
    else passed++;
    read_word(12'hF01, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL evt_cleared got %h want %h", got, exp);
    else passed++;
    btn_in = 4'b0101;
    for (int e = 1; e <= 5; e++) tick();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    read_word(12'hF01, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL evt_coinc_pre got %h want %h", got, exp);
    else passed++;
    read_word(12'hF01, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL evt_set_wins got %h want %h", got, exp);
    else passed++;
    read_word(12'hF01, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL evt_after got %h want %h", got, exp);
    else passed++;
    exp_q.push_back(32'h5);
    peek(12'hF00, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL state_0101 got %h want %h", got, exp);
    else passed++;
  endtask

  task automatic test_tick();
    write_word(12'hF05, 32'h0);
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
    exp_q.push_back(32'd5);
    read_word(12'hF05, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL tick_count got %h want %h", got, exp);
    else passed++;
    frame_tick = 1'b1;
    write_word(12'hF05, 32'h1234);
    frame_tick = 1'b0;
    exp_q.push_back(32'd0);
    read_word(12'hF05, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL tick_write_wins got %h want %h", got, exp);
    else passed++;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    exp_q.push_back(32'd1);
    peek(12'hF05, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL tick_after got %h want %h", got, exp);
    else passed++;
  endtask

  task automatic test_reset_mid();
    btn_in = 4'b0000;
    for (int i = 0; i < 8; i++) tick();
    exp_q.push_back(32'h0);
    peek(12'hF00, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL settle got %h want %h", got, exp);
    else passed++;
    btn_in = 4'b1000;
    for (int e = 1; e <= 10; e++) begin
      if (e == 4) reset = 1'b0;
      tick();
      reset = 1'b1;
      exp_q.push_back(e < 10 ? 32'h0 : 32'h8);
      peek(12'hF00, got);
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp)
        $display("FAIL mid_reset_edge%0d got %h want %h", e, got, exp);
      else passed++;
    end
    exp_q.push_back(32'h8);
    read_word(12'hF01, got);
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) $display("FAIL mid_reset_evt got %h want %h", got, exp);
    else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    io_address = 12'h0;
    io_wdata = 32'h0;
    io_wren = 1'b0;
    io_rden = 1'b0;
    btn_in = 4'b0;
    frame_tick = 1'b0;
    tick();
    test_reset();
    test_regs();
    test_debounce();
    test_event();
    test_tick();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/game_io_mmio.md
# game_io_mmio

Memory-mapped I/O responder on the processor's data-memory bus: decodes the processor's dmem address, write data and write enable, and the load strobe. It serves the debounced player buttons and a frame-tick counter as read-only registers, and holds the game-state registers (level, screen, game over) that the graphics side reads. It sits beside `dmem` in the top level. `io_sel` tells the top level to steer `io_rdata` into the processor's load data in place of `q_dmem`, and to gate `dmem` `wren`.

## Interface
- `IO_BASE`, 12'hF00: base address of the 16-word I/O window (`IO_BASE[3:0]` must be 0).
- `DEBOUNCE_CYCLES`, 50000: consecutive stable samples required to accept a button change; must be ≥ 2.
- `CNT_W`, 16: debounce counter width; must hold `DEBOUNCE_CYCLES-1`.
- `clock`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-low; takes effect on a rising edge of `clock` while low.
- `io_address`  input  12  processor dmem address.
- `io_wdata`  input  32  processor store data.
- `io_wren`  input  1  processor store strobe.
- `io_rden`  input  1  processor load strobe (lw in memory stage).
- `btn_in`  input  4  raw asynchronous push-buttons, active-high.
- `frame_tick`  input  1  one-cycle pulse per video frame, synchronous to `clock`.
- `io_sel`  output  1  `io_address[11:4] == IO_BASE[11:4]`; combinational.
- `io_rdata`  output  32  read data; combinational.
- `level_out`  output  8  LEVEL register.
- `screen_out`  output  4  SCREEN register.
- `game_over_out`  output  1  GAME_OVER register.

## Operation
- **Register map** (word offset = `io_address[3:0]`):
  - 0 BTN_STATE: RO; bits [3:0] are the debounced levels.
  - 1 BTN_EVENT: RO, clear-on-read; bits [3:0] are sticky press flags.
  - 2 LEVEL: RW; `wdata[7:0]`.
  - 3 SCREEN: RW; `wdata[3:0]`.
  - 4 GAME_OVER: RW; `wdata[0]`.
  - 5 TICK: 32-bit count of `frame_tick` pulses; any write clears it to 0.
  - 6–15: read 0; writes ignored.
  - Unused upper bits read 0.
- **`io_rdata`**: 0 whenever `io_sel` = 0.
- **Writes**: accepted only when `io_wren && io_sel`.
- **Reads**: `io_rden` has no side effect except on BTN_EVENT.
- **Synchronizer**: 2 flops per button (s1 → s2).
- **Debouncer**, per bit, evaluated each edge:
  - If s2 == deb: cnt ← 0.
  - Else if cnt == `DEBOUNCE_CYCLES-1`: deb ← s2 and cnt ← 0.
  - Else: cnt ← cnt+1.
- **Press event**: on the edge where deb goes 0→1, the matching event bit sets.
- **Event clear**: on the edge where `io_rden && io_sel && offset==1`, BTN_EVENT ← 0, except that a bit setting on that same edge remains 1 (set wins).
- **TICK**: increments by 1 on each `frame_tick` edge and wraps 32'hFFFFFFFF → 0. Write-clear and tick on the same edge gives 0 (write wins).
- **Simultaneous `io_wren` and `io_rden`**: the write is performed, and the read side effect also applies.
- **Reset**: all flops go to 0 (s1, s2, deb, cnt, events, LEVEL, SCREEN, GAME_OVER, TICK).
  - Reset outputs: `level_out`=0, `screen_out`=0, `game_over_out`=0.
  - `io_rdata` and `io_sel` follow their inputs.
  - Reset mid-debounce discards the partial count.

## Timing
- Read latency is 0: `io_rdata` is valid in the same cycle as `io_address`, ahead of the processor's sampling edge.
- Write latency is 1: a register changes on the rising edge ending the `io_wren` cycle and is visible at the outputs after that edge.
- Button latency: a `btn_in` change stable before edge 1 appears in BTN_STATE after edge `DEBOUNCE_CYCLES+2`.
  - Any bounce resets the count.
  - The event bit sets on that same edge.
- BTN_EVENT read-then-clear: the read cycle returns the pre-clear value, and the next cycle reads the cleared value.
- `frame_tick` at edge k appears in TICK after edge k.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `IO_BASE`=12'hF00.
- **Reset:** hold `reset`=0 for 2 edges after writing LEVEL=8'h55 → `level_out`=0, `screen_out`=0, `game_over_out`=0; read 12'hF05 → 0.
- **Register writes:** write 32'h1A3 to F02, 32'h7 to F03, 32'h1 to F04; write 32'hFF to F06.
  - Next cycle: `level_out`=8'hA3, `screen_out`=4'h7, `game_over_out`=1.
  - Readbacks: F02 reads 32'hA3; F06 reads 0.
  - Address F10 gives `io_sel`=0 and `io_rdata`=0.
- **Debounce:**
  - Raise `btn_in[2]` and hold → BTN_STATE=4'b0100 after edge 6, not before.
  - Pulse `btn_in[1]` high for 3 cycles → BTN_STATE never changes.
- **Event clear-on-read:**
  - After the press above, read F01 → 32'h4; read again → 0.
  - A `btn_in[0]` press whose accept edge coincides with the read-clear edge → the second read returns 32'h1.
- **Tick:**
  - 5 `frame_tick` pulses → F05 reads 5.
  - Write F05 on a cycle with `frame_tick`=1 → reads 0 afterwards.
- **Reset mid-debounce:** raise `btn_in[3]` and assert `reset` at edge 4 for one edge → BTN_STATE reads 0 through edge 6 and becomes 4'b1000 only after 6 further edges.
